// File: rtl/ysyx_25070198_bus_pkg.sv
// Shared types and defaults for the IFU/LSU data-memory arbiter.
package ysyx_25070198_bus_pkg;

  localparam int ADDR_W_DEF       = 32;
  localparam int DATA_W_DEF       = 32;
  localparam int TIMEOUT_DEF      = 255;
  localparam int WD_CNT_MIN_W     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } arb_state_t;

  typedef enum logic {
    MST_IFU = 1'b0,
    MST_LSU = 1'b1
  } master_id_t;

  // Watchdog width: wide enough for the limit, never narrower than 8 bits.
  function automatic int wd_cnt_w(input int limit);
    int w;
    w = $clog2(limit + 1);
    return (w > WD_CNT_MIN_W) ? w : WD_CNT_MIN_W;
  endfunction

endpackage

// File: rtl/ysyx_25070198_rr_pick.sv
// Two-input round-robin pick: on a tie the master that was not granted last wins.
module ysyx_25070198_rr_pick
  import ysyx_25070198_bus_pkg::*;
(
  input  logic       ifu_req,
  input  logic       lsu_req,
  input  master_id_t last_grant,
  output master_id_t grant
);

  always_comb begin
    grant = MST_IFU;
    if (ifu_req && lsu_req) begin
      grant = (last_grant == MST_LSU) ? MST_IFU : MST_LSU;
    end else if (lsu_req) begin
      grant = MST_LSU;
    end
  end

endmodule

// File: rtl/ysyx_25070198_mem_arb.sv
// IFU/LSU arbiter for the single data-memory port, one transaction at a time.
// Optional watchdog enabled by defining YSYX_25070198_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a request; grant and register the command
// REQ   | mem_reqValid high, command held until mem_reqReady
// RESP  | waiting for mem_respValid, capture rdata
// DONE  | one-cycle respValid pulse to the owning master
module ysyx_25070198_mem_arb
  import ysyx_25070198_bus_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ifu_reqValid,
  input  logic [ADDR_W-1:0]   ifu_raddr,
  output logic                ifu_respValid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_respErr,
  input  logic                lsu_reqValid,
  input  logic                lsu_wen,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_respValid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_respErr,
  output logic                mem_reqValid,
  input  logic                mem_reqReady,
  output logic                mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_respValid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_t          state_q, state_d;
  master_id_t          last_grant_q, owner_q, pick;
  logic                wen_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wmask_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                grant_en;
  logic                resp_take;
  logic                wd_expire;
  logic                err;

  ysyx_25070198_rr_pick u_rr_pick (
    .ifu_req    (ifu_reqValid),
    .lsu_req    (lsu_reqValid),
    .last_grant (last_grant_q),
    .grant      (pick)
  );

  assign grant_en  = (state_q == IDLE) && (ifu_reqValid || lsu_reqValid);
  assign resp_take = (state_q == RESP) && mem_respValid;

`ifdef YSYX_25070198_ARB_TIMEOUT_EN
  localparam int CNT_W = wd_cnt_w(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] wd_cnt_q;
  logic             err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q <= '0;
    end else if (grant_en) begin
      wd_cnt_q <= '0;
    end else if (state_q == REQ || state_q == RESP) begin
      wd_cnt_q <= wd_cnt_q + 1'b1;
    end
  end

  // Grant cycle counts as cycle 0, so the forced DONE lands on cycle TIMEOUT_CYCLES.
  assign wd_expire = (state_q == REQ || state_q == RESP) &&
                     (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (grant_en) begin
      err_q <= 1'b0;
    end else if (wd_expire) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign wd_expire = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (grant_en) state_d = REQ;
      REQ: begin
        if (wd_expire) state_d = DONE;
        else if (mem_reqReady) state_d = RESP;
      end
      RESP: begin
        if (wd_expire || mem_respValid) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= MST_LSU;
      owner_q      <= MST_IFU;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
    end else if (grant_en) begin
      last_grant_q <= pick;
      owner_q      <= pick;
      if (pick == MST_IFU) begin
        wen_q   <= 1'b0;
        addr_q  <= ifu_raddr;
        wdata_q <= '0;
        wmask_q <= '0;
      end else begin
        wen_q   <= lsu_wen;
        addr_q  <= lsu_addr;
        wdata_q <= lsu_wdata;
        wmask_q <= lsu_wmask;
      end
    end
  end

  // A timeout wins over a response arriving in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (wd_expire) begin
      rdata_q <= '0;
    end else if (resp_take) begin
      rdata_q <= mem_rdata;
    end
  end

  assign mem_reqValid  = (state_q == REQ);
  assign mem_wen       = wen_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign busy          = (state_q != IDLE);

  assign ifu_respValid = (state_q == DONE) && (owner_q == MST_IFU);
  assign lsu_respValid = (state_q == DONE) && (owner_q == MST_LSU);
  assign ifu_rdata     = ifu_respValid ? rdata_q : '0;
  assign lsu_rdata     = lsu_respValid ? rdata_q : '0;
  assign ifu_respErr   = ifu_respValid & err;
  assign lsu_respErr   = lsu_respValid & err;

endmodule

// File: tb/tb_ysyx_25070198_mem_arb.sv
// Directed bench for the IFU/LSU memory arbiter with a small memory responder.
module tb_ysyx_25070198_mem_arb;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ifu_reqValid, ifu_respValid, ifu_respErr;
  logic [AW-1:0] ifu_raddr;
  logic [DW-1:0] ifu_rdata;
  logic          lsu_reqValid, lsu_wen, lsu_respValid, lsu_respErr;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata, lsu_rdata;
  logic [3:0]    lsu_wmask;
  logic          mem_reqValid, mem_reqReady, mem_wen, mem_respValid, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [3:0]    mem_wmask;

  int n_checks = 0;
  int n_errs   = 0;

  int          ready_dly   = 0;
  int          wait_cnt    = 0;
  bit          pend        = 1'b0;
  bit          mem_silent  = 1'b0;
  bit          inject_resp = 1'b0;
  logic [31:0] resp_data   = '0;

  ysyx_25070198_mem_arb #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ifu_reqValid  (ifu_reqValid),
    .ifu_raddr     (ifu_raddr),
    .ifu_respValid (ifu_respValid),
    .ifu_rdata     (ifu_rdata),
    .ifu_respErr   (ifu_respErr),
    .lsu_reqValid  (lsu_reqValid),
    .lsu_wen       (lsu_wen),
    .lsu_addr      (lsu_addr),
    .lsu_wdata     (lsu_wdata),
    .lsu_wmask     (lsu_wmask),
    .lsu_respValid (lsu_respValid),
    .lsu_rdata     (lsu_rdata),
    .lsu_respErr   (lsu_respErr),
    .mem_reqValid  (mem_reqValid),
    .mem_reqReady  (mem_reqReady),
    .mem_wen       (mem_wen),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_respValid (mem_respValid),
    .mem_rdata     (mem_rdata),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Memory model: accepts after ready_dly REQ cycles, responds the cycle after acceptance.
  always @(negedge clk) begin
    mem_reqReady  = 1'b0;
    mem_respValid = inject_resp;
    mem_rdata     = resp_data;
    if (!rst_n) begin
      pend     = 1'b0;
      wait_cnt = 0;
    end else if (pend) begin
      if (!mem_silent) begin
        mem_respValid = 1'b1;
        pend          = 1'b0;
      end
    end else if (mem_reqValid) begin
      if (wait_cnt == ready_dly) begin
        mem_reqReady = 1'b1;
        pend         = 1'b1;
        wait_cnt     = 0;
      end else begin
        wait_cnt++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int req_cycles, pulses, wrong, ng, nr;
    logic prev;
    logic [31:0] got [4];
    logic [31:0] rv  [4];

    ifu_reqValid = 0; ifu_raddr = '0;
    lsu_reqValid = 0; lsu_wen = 0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;

    repeat (2) tick();
    chk("rst_busy", busy, 0);
    chk("rst_mem_reqValid", mem_reqValid, 0);
    chk("rst_ifu_respValid", ifu_respValid, 0);
    chk("rst_lsu_respValid", lsu_respValid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    rst_n = 1;
    tick();

    // IFU-only read, minimum latency
    resp_data = 32'h0010_0093; ready_dly = 0;
    ifu_reqValid = 1; ifu_raddr = 32'h8000_0000;
    tick();
    chk("t1_c1_reqValid", mem_reqValid, 1);
    chk("t1_c1_addr", mem_addr, 32'h8000_0000);
    chk("t1_c1_wmask", mem_wmask, 0);
    chk("t1_c1_wen", mem_wen, 0);
    tick();
    chk("t1_c2_reqValid", mem_reqValid, 0);
    chk("t1_c2_ifu_respValid", ifu_respValid, 0);
    tick();
    chk("t1_c3_ifu_respValid", ifu_respValid, 1);
    chk("t1_c3_ifu_rdata", ifu_rdata, 32'h0010_0093);
    chk("t1_c3_ifu_respErr", ifu_respErr, 0);
    chk("t1_c3_lsu_respValid", lsu_respValid, 0);
    chk("t1_c3_lsu_rdata", lsu_rdata, 0);
    ifu_reqValid = 0;
    tick();
    chk("t1_c4_ifu_respValid", ifu_respValid, 0);
    chk("t1_c4_busy", busy, 0);

    // LSU store with delayed acceptance; inputs wiggle mid-transaction
    ready_dly = 3;
    lsu_wen = 1; lsu_addr = 32'h8000_1004; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0100;
    lsu_reqValid = 1;
    req_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!mem_reqValid) break;
      req_cycles++;
      chk("t2_addr", mem_addr, 32'h8000_1004);
      chk("t2_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("t2_wmask", mem_wmask, 4'b0100);
      chk("t2_wen", mem_wen, 1);
      if (i == 1) begin
        lsu_addr = 32'h1234_5678; lsu_wdata = 32'h0; lsu_wmask = 4'b1111;
      end
    end
    chk("t2_req_cycles", req_cycles, 4);
    pulses = 0; wrong = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (lsu_respValid) begin
        pulses++;
        lsu_reqValid = 0;
      end
      if (ifu_respValid) wrong++;
    end
    chk("t2_lsu_pulses", pulses, 1);
    chk("t2_ifu_pulses", wrong, 0);
    lsu_reqValid = 0; lsu_wen = 0;

    // Simultaneous requests right after reset: IFU first, then alternate
    rst_n = 0; tick(); rst_n = 1; tick();
    ready_dly = 0;
    ifu_reqValid = 1; ifu_raddr = 32'h8000_0100;
    lsu_reqValid = 1; lsu_wen = 0; lsu_addr = 32'h8000_2200; lsu_wmask = 4'b1111;
    ng = 0; nr = 0; prev = 0;
    for (int i = 0; i < 40 && ng < 4; i++) begin
      tick();
      if (mem_reqValid && !prev) begin
        got[ng] = mem_addr;
        ng++;
      end
      if (nr < 4 && ifu_respValid) begin rv[nr] = 0; nr++; end
      if (nr < 4 && lsu_respValid) begin rv[nr] = 1; nr++; end
      prev = mem_reqValid;
    end
    chk("t3_grant_count", ng, 4);
    chk("t3_grant0", got[0], 32'h8000_0100);
    chk("t3_grant1", got[1], 32'h8000_2200);
    chk("t3_grant2", got[2], 32'h8000_0100);
    chk("t3_grant3", got[3], 32'h8000_2200);
    chk("t3_resp_count", nr, 3);
    chk("t3_resp0_owner", rv[0], 0);
    chk("t3_resp1_owner", rv[1], 1);
    chk("t3_resp2_owner", rv[2], 0);
    ifu_reqValid = 0; lsu_reqValid = 0;
    repeat (6) tick();
    chk("t3_drain_busy", busy, 0);

    // Reset asserted while waiting for the response
    ifu_reqValid = 1; ifu_raddr = 32'h8000_0040;
    tick();
    tick();
    chk("t4_in_resp_busy", busy, 1);
    #2;
    rst_n = 0; ifu_reqValid = 0;
    #1;
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_mem_reqValid", mem_reqValid, 0);
    chk("t4_rst_mem_addr", mem_addr, 0);
    chk("t4_rst_ifu_respValid", ifu_respValid, 0);
    tick(); tick();
    rst_n = 1;
    tick();
    inject_resp = 1;
    wrong = 0;
    repeat (3) begin
      tick();
      if (ifu_respValid || lsu_respValid) wrong++;
    end
    inject_resp = 0;
    tick();
    chk("t4_post_rst_resp", wrong, 0);
    chk("t4_post_rst_busy", busy, 0);

    // Stray memory response while idle
    inject_resp = 1;
    wrong = 0;
    repeat (2) begin
      tick();
      if (ifu_respValid || lsu_respValid || busy) wrong++;
    end
    inject_resp = 0;
    tick();
    chk("t6_idle_resp_ignored", wrong, 0);

    // Memory never responds
    mem_silent = 1;
    ifu_reqValid = 1; ifu_raddr = 32'h8000_0080;
`ifdef YSYX_25070198_ARB_TIMEOUT_EN
    for (int k = 1; k <= TO; k++) begin
      tick();
      if (k == TO - 1) chk("t5_before_timeout", ifu_respValid, 0);
    end
    chk("t5_to_respValid", ifu_respValid, 1);
    chk("t5_to_respErr", ifu_respErr, 1);
    chk("t5_to_rdata", ifu_rdata, 0);
    chk("t5_to_lsu_respValid", lsu_respValid, 0);
    ifu_reqValid = 0;
    tick();
    chk("t5_after_busy", busy, 0);
    mem_silent = 0;
    wrong = 0;
    repeat (3) begin
      tick();
      if (ifu_respValid || lsu_respValid) wrong++;
    end
    chk("t5_late_resp_ignored", wrong, 0);
`else
    wrong = 0;
    repeat (20) begin
      tick();
      if (ifu_respValid || lsu_respValid) wrong++;
    end
    chk("t5_hang_busy", busy, 1);
    chk("t5_hang_no_resp", wrong, 0);
    chk("t5_hang_respErr", ifu_respErr, 0);
`endif
    ifu_reqValid = 0;
    rst_n = 0; tick();
    mem_silent = 0; rst_n = 1; tick();
    chk("end_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
